// File: rtl/div_operand_normalizer.sv
// Operand normalization ahead of the iterative integer divider.
// Stage 1 registers the operand pair together with the one-hot MSB of each operand.
// Stage 2 turns those into a divisor shift amount, a left-justified divisor,
// the iteration count and a divide-by-zero flag.
// The two stages form a valid/ready pipeline with throughput 1/cycle.

// Fixed-priority arbiter: the lowest-index request wins.
// Feeding it a bit-reversed operand makes the grant mark the operand MSB.
module div_lead_arb #(
   parameter int N = 32
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   // Isolate the lowest set request bit (req & -req).
   always_comb begin
      gnt = req & (~req + {{(N-1){1'b0}}, 1'b1});
   end

endmodule

module div_operand_normalizer #(
   parameter int N = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N-1:0]          dividend,
   input  logic [N-1:0]          divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N-1:0]          out_dividend,
   output logic [N-1:0]          out_norm_dsr,
   output logic [$clog2(N)-1:0]  out_shift,
   output logic [$clog2(N):0]    out_iters,
   output logic                  out_dbz
);

   localparam int SW = $clog2(N);
   localparam int CW = $clog2(N) + 1;
   localparam logic [SW-1:0] MAX_IDX = SW'(N - 1);

   logic          s1_valid_r;
   logic [N-1:0]  s1_dividend_r;
   logic [N-1:0]  s1_divisor_r;
   logic [N-1:0]  s1_oh_a_r;
   logic [N-1:0]  s1_oh_b_r;
   logic          s1_zero_a_r;
   logic          s1_zero_b_r;

   logic [N-1:0]  rev_a_s;
   logic [N-1:0]  rev_b_s;
   logic [N-1:0]  gnt_a_s;
   logic [N-1:0]  gnt_b_s;
   logic [N-1:0]  oh_a_s;
   logic [N-1:0]  oh_b_s;

   logic          s1_en_s;
   logic          s2_en_s;
   logic [SW-1:0] msb_a_s;
   logic [SW-1:0] msb_b_s;
   logic [SW-1:0] shift_s;
   logic [N-1:0]  norm_s;
   logic [CW-1:0] iters_s;

   // Bit-reverse both operands so the arbiter's lowest-index priority picks the MSB.
   always_comb begin
      rev_a_s = {N{1'b0}};
      rev_b_s = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         rev_a_s[i] = dividend[N-1-i];
         rev_b_s[i] = divisor[N-1-i];
      end
   end

   div_lead_arb #(.N(N)) u_arb_a (.req(rev_a_s), .gnt(gnt_a_s));
   div_lead_arb #(.N(N)) u_arb_b (.req(rev_b_s), .gnt(gnt_b_s));

   // Undo the reversal so the one-hot bit sits at the operand's MSB position.
   always_comb begin
      oh_a_s = {N{1'b0}};
      oh_b_s = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         oh_a_s[i] = gnt_a_s[N-1-i];
         oh_b_s[i] = gnt_b_s[N-1-i];
      end
   end

   // Pipeline advance: a stage moves when it is empty or its consumer moves.
   always_comb begin
      s2_en_s  = ~out_valid | out_ready;
      s1_en_s  = ~s1_valid_r | s2_en_s;
      in_ready = s1_en_s;
   end

   // Stage 1 register: operands, MSB one-hots and zero flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r    <= 1'b0;
         s1_dividend_r <= {N{1'b0}};
         s1_divisor_r  <= {N{1'b0}};
         s1_oh_a_r     <= {N{1'b0}};
         s1_oh_b_r     <= {N{1'b0}};
         s1_zero_a_r   <= 1'b0;
         s1_zero_b_r   <= 1'b0;
      end else if (s1_en_s) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_dividend_r <= dividend;
            s1_divisor_r  <= divisor;
            s1_oh_a_r     <= oh_a_s;
            s1_oh_b_r     <= oh_b_s;
            s1_zero_a_r   <= ~|dividend;
            s1_zero_b_r   <= ~|divisor;
         end
      end
   end

   // One-hot to index encode; a zero vector encodes to index 0.
   always_comb begin
      msb_a_s = {SW{1'b0}};
      msb_b_s = {SW{1'b0}};
      for (int i = 0; i < N; i++) begin
         msb_a_s = msb_a_s | (s1_oh_a_r[i] ? SW'(i) : {SW{1'b0}});
         msb_b_s = msb_b_s | (s1_oh_b_r[i] ? SW'(i) : {SW{1'b0}});
      end
   end

   // Normalization results; a zero divisor forces shift, divisor and count to zero.
   always_comb begin
      shift_s = {SW{1'b0}};
      norm_s  = {N{1'b0}};
      iters_s = {CW{1'b0}};
      if (s1_zero_b_r) begin
         shift_s = {SW{1'b0}};
         norm_s  = {N{1'b0}};
         iters_s = {CW{1'b0}};
      end else begin
         shift_s = MAX_IDX - msb_b_s;
         norm_s  = s1_divisor_r << shift_s;
         if (s1_zero_a_r || (msb_b_s > msb_a_s)) begin
            iters_s = {CW{1'b0}};
         end else begin
            iters_s = {1'b0, msb_a_s} - {1'b0, msb_b_s} + {{(CW-1){1'b0}}, 1'b1};
         end
      end
   end

   // Stage 2 register drives the outputs; held while the core stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_dividend <= {N{1'b0}};
         out_norm_dsr <= {N{1'b0}};
         out_shift    <= {SW{1'b0}};
         out_iters    <= {CW{1'b0}};
         out_dbz      <= 1'b0;
      end else if (s2_en_s) begin
         out_valid <= s1_valid_r;
         if (s1_valid_r) begin
            out_dividend <= s1_dividend_r;
            out_norm_dsr <= norm_s;
            out_shift    <= shift_s;
            out_iters    <= iters_s;
            out_dbz      <= s1_zero_b_r;
         end
      end
   end

endmodule
